// File: rtl/seg_scan_controller.sv
// Multiplexed seven-segment scanner: owns the refresh prescaler and digit index,
// decodes hex to active-low segments, and adds PWM dimming, blanking and frame-synchronous data update.
module seg_scan_controller #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int BRIGHT_W    = 4,
  parameter int BLANK_CYC   = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [4*NUM_DIGITS-1:0]   digit_data,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  input  logic [BRIGHT_W-1:0]       brightness,
  input  logic                      load,
  output logic [NUM_DIGITS-1:0]     digit,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic                      frame_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [63:0]      BLANK64  = 64'(BLANK_CYC);

  logic [PRE_W-1:0]          r_presc;
  logic [IDX_W-1:0]          r_idx;
  logic [4*NUM_DIGITS-1:0]   r_pend_data;
  logic [NUM_DIGITS-1:0]     r_pend_dp;
  logic                      r_pend_valid;
  logic [4*NUM_DIGITS-1:0]   r_act_data;
  logic [NUM_DIGITS-1:0]     r_act_dp;

  logic                      w_slot_end;
  logic                      w_wrap;
  logic [63:0]               w_on_cnt;
  logic [63:0]               w_presc64;
  logic                      w_anode_on;
  logic [3:0]                w_nibble;
  logic [NUM_DIGITS-1:0]     w_digit;

  // Standard hex glyphs, cathodes {g,f,e,d,c,b,a}, active low.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  // 64-bit product keeps (brightness+1)*REFRESH_DIV exact for any practical divider.
  function automatic logic [63:0] calc_on_cnt(input logic [BRIGHT_W-1:0] b);
    logic [63:0] prod;
    prod = (64'(b) + 64'd1) * 64'(REFRESH_DIV);
    calc_on_cnt = prod >> BRIGHT_W;
  endfunction

  assign w_slot_end = (r_presc == PRE_LAST);
  assign w_wrap     = w_slot_end && (r_idx == IDX_LAST);
  assign w_on_cnt   = calc_on_cnt(brightness);
  assign w_presc64  = 64'(r_presc);
  assign w_anode_on = digit_en[r_idx] && (w_presc64 >= BLANK64) && (w_presc64 < w_on_cnt);
  assign w_nibble   = r_act_data[{r_idx, 2'b00} +: 4];

  always_comb begin
    w_digit = '1;
    if (w_anode_on) w_digit[r_idx] = 1'b0;
  end

  // Scan timing: prescaler within a slot, index across slots.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (w_slot_end) begin
      r_presc <= '0;
      r_idx   <= w_wrap ? '0 : r_idx + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Double-buffered display data; active only changes on a frame wrap so a frame never mixes loads.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pend_data  <= '0;
      r_pend_dp    <= '0;
      r_pend_valid <= 1'b0;
      r_act_data   <= '0;
      r_act_dp     <= '0;
    end else if (load && w_wrap) begin
      r_act_data   <= digit_data;
      r_act_dp     <= dp_in;
      r_pend_valid <= 1'b0;
    end else if (load) begin
      r_pend_data  <= digit_data;
      r_pend_dp    <= dp_in;
      r_pend_valid <= 1'b1;
    end else if (w_wrap && r_pend_valid) begin
      r_act_data   <= r_pend_data;
      r_act_dp     <= r_pend_dp;
      r_pend_valid <= 1'b0;
    end
  end

  // Output register stage: one cycle behind (prescaler, index).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      digit      <= '1;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      digit      <= w_digit;
      seg        <= hex_to_seg(w_nibble);
      dp         <= ~r_act_dp[r_idx];
      frame_tick <= w_wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Randomized scoreboard bench for seg_scan_controller; a time-based reference model
// predicts every output cycle and a monitor compares on the falling edge.
module tb_seg_scan_controller;
  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BW = 2;
  localparam int BL = 1;
  localparam int FRAME = ND * RD;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [4*ND-1:0]   digit_data;
  logic [ND-1:0]     dp_in;
  logic [ND-1:0]     digit_en;
  logic [BW-1:0]     brightness;
  logic              load;
  logic [ND-1:0]     digit;
  logic [6:0]        seg;
  logic              dp;
  logic              frame_tick;

  seg_scan_controller #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BRIGHT_W(BW), .BLANK_CYC(BL)) dut (
    .clk(clk), .reset_n(reset_n), .digit_data(digit_data), .dp_in(dp_in),
    .digit_en(digit_en), .brightness(brightness), .load(load),
    .digit(digit), .seg(seg), .dp(dp), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ND-1:0] dig;
    logic [6:0]    sg;
    logic          d;
    logic          ft;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_err = 0;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: position in the scan is derived purely from cycles elapsed since reset.
  int unsigned     m_t = 0;
  logic [4*ND-1:0] m_act = '0, m_pend = '0;
  logic [ND-1:0]   m_adp = '0, m_pdp = '0;
  bit              m_pv = 0;

  always @(posedge clk) begin
    exp_t e;
    int unsigned p, ix, on;
    bit wrap;
    if (!reset_n) begin
      e.dig = '1; e.sg = 7'h7F; e.d = 1'b1; e.ft = 1'b0;
      m_t = 0; m_act = '0; m_pend = '0; m_adp = '0; m_pdp = '0; m_pv = 0;
    end else begin
      p    = m_t % RD;
      ix   = (m_t / RD) % ND;
      on   = ((int'(brightness) + 1) * RD) >> BW;
      wrap = (m_t % FRAME) == FRAME - 1;
      e.dig = '1;
      if (digit_en[ix] && p >= BL && p < on) e.dig[ix] = 1'b0;
      e.sg = glyph[m_act[ix*4 +: 4]];
      e.d  = ~m_adp[ix];
      e.ft = wrap;
      if (load && wrap) begin
        m_act = digit_data; m_adp = dp_in; m_pv = 0;
      end else if (load) begin
        m_pend = digit_data; m_pdp = dp_in; m_pv = 1;
      end else if (wrap && m_pv) begin
        m_act = m_pend; m_adp = m_pdp; m_pv = 0;
      end
      m_t = m_t + 1;
    end
    q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_chk = n_chk + 1;
      if ({digit, seg, dp, frame_tick} !== e) begin
        n_err = n_err + 1;
        $display("FAIL outputs t=%0t got dig=%h seg=%h dp=%b ft=%b want dig=%h seg=%h dp=%b ft=%b",
                 $time, digit, seg, dp, frame_tick, e.dig, e.sg, e.d, e.ft);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic check_reset(input string tag);
    n_chk = n_chk + 1;
    if (digit !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_tick !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL reset state (%s) t=%0t got dig=%h seg=%h dp=%b ft=%b",
               tag, $time, digit, seg, dp, frame_tick);
    end
  endtask

  // Advance until the model's frame position equals ph (ph = idx*RD + prescaler).
  task automatic wait_phase(input int unsigned ph);
    int guard;
    guard = 0;
    do begin
      step();
      guard++;
    end while ((m_t % FRAME) != ph && guard < 4 * FRAME);
    n_chk = n_chk + 1;
    if ((m_t % FRAME) != ph) begin
      n_err = n_err + 1;
      $display("FAIL wait_phase(%0d) expired t=%0t", ph, $time);
    end
  endtask

  task automatic do_load(input logic [4*ND-1:0] d, input logic [ND-1:0] p);
    digit_data = d; dp_in = p; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; digit_data = '0; dp_in = '0; digit_en = 4'hF;
    brightness = 2'd3; load = 1'b0;
    run(3);
    check_reset("power-on");
    reset_n = 1'b1;
    run(40);
    wait_phase(10);
    do_load(16'h1A8F, 4'b0100);
    run(70);
    brightness = 2'd0; run(FRAME);
    brightness = 2'd1; run(FRAME);
    brightness = 2'd3;
    digit_en = 4'b1010; run(40);
    digit_en = 4'hF;
    wait_phase(3);
    do_load(16'h1111, 4'b0001);
    run(5);
    do_load(16'h2222, 4'b0010);
    run(40);
    wait_phase(FRAME - 1);
    do_load(16'h3333, 4'b1000);
    run(40);
    wait_phase(2 * RD + 5);
    reset_n = 1'b0; step();
    check_reset("mid-scan");
    reset_n = 1'b1; run(40);
    for (int i = 0; i < 3000; i++) begin
      load       = ($urandom_range(0, 15) == 0);
      digit_data = 16'($urandom);
      dp_in      = 4'($urandom);
      if ($urandom_range(0, 63) == 0) brightness = 2'($urandom);
      if ($urandom_range(0, 63) == 0) digit_en = 4'($urandom);
      reset_n    = ($urandom_range(0, 499) != 0);
      step();
    end
    load = 1'b0; reset_n = 1'b1;
    run(2);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/seg_scan_controller.md
Name: seg_scan_controller

Overview:
- Parametrised multiplexed seven-segment scanner; successor to the fixed 8-digit, externally-counted anode decoder.
- Owns the refresh prescaler and digit index, and decodes hex nibbles to active-low segments.
- Adds a per-digit enable mask, per-digit decimal points, PWM brightness, anti-ghosting blanking and tear-free frame-synchronous data update.
- Sits between the terminal/display-buffer logic and the board's anode and cathode pins.

Parameters:
NUM_DIGITS, 8, number of multiplexed digits (1..16)
REFRESH_DIV, 100000, clock cycles per digit slot (>=2)
BRIGHT_W, 4, brightness control width
BLANK_CYC, 64, cycles at slot start with anode forced off (< REFRESH_DIV)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
digit_data  in  4*NUM_DIGITS  hex nibble per digit; nibble i = digit i, digit 0 right-most
dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit
digit_en  in  NUM_DIGITS  per-digit enable; 0 = digit dark, slot still consumed
brightness  in  BRIGHT_W  PWM duty select; all-ones = full on-time
load  in  1  one-cycle strobe; captures digit_data and dp_in
digit  out  NUM_DIGITS  anode drives, active low, one-hot-low or all ones
seg  out  7  cathodes {g,f,e,d,c,b,a}, active low
dp  out  1  decimal-point cathode, active low
frame_tick  out  1  one-cycle pulse when scan index wraps to 0

Behaviour:
- One clock and one reset. The reset is synchronous and active-low (reset_n sampled on rising clk). All state is registered.
- Reset values:
  - digit = all ones, seg = 7'h7F, dp = 1, frame_tick = 0.
  - prescaler = 0, index = 0.
  - pending and active data/dp registers = 0, pending_valid = 0.
- Prescaler: counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1 it returns to 0 and index increments.
  - index wraps from NUM_DIGITS-1 to 0. Index width = max(1, clog2(NUM_DIGITS)).
  - With NUM_DIGITS = 1, index stays 0 and every slot is a frame.
- frame_tick: registered, high for exactly the cycle in which index first equals 0 after a wrap. Not asserted on reset exit.
- Data capture:
  - load copies digit_data/dp_in into pending and sets pending_valid.
  - At a wrap edge with pending_valid set, pending is copied to active and pending_valid is cleared.
  - If load coincides with the wrap edge, the inputs go directly to active and pending_valid is cleared.
  - Multiple loads within a frame: the last one wins.
  - The displayed digits never mix two loads within one frame.
- Duty:
  - on_cnt = ((brightness+1) * REFRESH_DIV) >> BRIGHT_W. Use full-width intermediate arithmetic; no overflow for REFRESH_DIV < 2^24.
  - Anode active when digit_en[index] and BLANK_CYC <= prescaler < on_cnt.
  - If on_cnt <= BLANK_CYC, the digit is always dark.
- Outputs: registered, 1-cycle latency from (prescaler, index).
  - digit[index] = 0 when the anode is active; all other bits = 1.
  - seg = hex decode of active nibble[index], using standard 0-F glyphs, e.g. 0 -> 7'h40, 8 -> 7'h00, F -> 7'h0E.
  - dp = ~active_dp[index].
  - seg and dp are driven regardless of the anode state.
- digit_en changes take effect on the next cycle; no frame synchronisation.
- brightness changes take effect immediately.
- Reset mid-scan: the next cycle shows reset values and the scan restarts at index 0, prescaler 0.

Test Plan:
Test parameters: NUM_DIGITS=4, REFRESH_DIV=8, BRIGHT_W=2, BLANK_CYC=1.
- Reset then run with brightness=3, digit_en=4'hF, nothing loaded:
  - digit goes 4'hF for 1 cycle, then 4'hE for 7 cycles, then 4'hF, 4'hD x7, and so on.
  - seg = 7'h40 throughout.
  - frame_tick pulses every 32 cycles.
- load with digit_data=16'h1A8F, dp_in=4'b0100 mid-frame:
  - Old values are held until frame_tick.
  - Next frame: seg per slot = 7'h0E, 7'h00, 7'h08, 7'h79; dp low only in slot 2.
- brightness=0 (on_cnt=2): each anode low for exactly 1 cycle (prescaler=1) per 8-cycle slot.
- brightness=1 (on_cnt=4): each anode low for 3 cycles per slot.
- digit_en=4'b1010: slots 0 and 2 keep digit=4'hF for the full 8 cycles; frame period is still 32 cycles.
- Two loads (16'h1111 then 16'h2222) in one frame, plus a third load (16'h3333) on the wrap cycle:
  - First case: the frame after the two loads shows 2222.
  - Wrap case: 3333 is shown from index 0 of the new frame.
- reset_n low at index 2, prescaler 5:
  - Next cycle: digit=4'hF, seg=7'h7F.
  - After release: scan resumes from digit 0; active data is cleared to 0.
